multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle control sequencer for the RV32I-subset core. Steps one instruction through
//  IDLE/FETCH/DECODE/EXECUTE/MEM/WB and drives datapath control per state from opcode_i
//  (IR[6:0]). Shares one memory port between fetch and load/store through a req/ready
//  handshake. Provides a retired-instruction counter and a sticky error/trap state.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles on mem_ready_i before trap; 0 = timeout disabled
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      reset, asynchronous, active-high
//  opcode_i       in   7      IR[6:0], valid from DECODE onward
//  mem_ready_i    in   1      memory completes current request this cycle
//  mem_req_o      out  1      memory request, held until accepted
//  mem_we_o       out  1      1 = store write (MEM state only)
//  iord_o         out  1      mem address select: 0 = PC, 1 = ALU result register
//  ir_write_o     out  1      load IR from memory read data
//  pc_write_o     out  1      PC <= PC+4 (dedicated adder)
//  branch_o       out  1      PC <= target if ALU compare taken
//  alu_src_o      out  1      ALU operand B: 0 = rs2, 1 = immediate
//  alu_op_o       out  2      00 add, 01 branch compare, 10 R-type funct, 11 OP-IMM funct
//  reg_write_o    out  1      register-file write enable
//  mem_to_reg_o   out  1      writeback source: 0 = ALU, 1 = memory data
//  state_o        out  3      IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WB=5 TRAP=6
//  retire_o       out  1      one-cycle pulse per completed instruction
//  retired_cnt_o  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
//  err_code_o     out  2      00 none, 01 illegal opcode, 10 memory timeout (sticky)
// BEHAVIOUR
//  Reset: state IDLE, retired_cnt_o=0, err_code_o=0, wait counter=0. All outputs are 0.
//  Reset mid-instruction aborts immediately. No partial write follows.
//  Classes (latched in DECODE): OPIMM 0010011, RTYPE 0110011, BRANCH 1100011,
//   LOAD 0000011, STORE 0100011. Any other opcode is illegal.
//  IDLE: all controls 0; -> FETCH next cycle unconditionally.
//  FETCH: mem_req_o=1, iord_o=0. On mem_ready_i=1: ir_write_o=1 and pc_write_o=1 in that
//   same cycle (Mealy), then -> DECODE.
//  DECODE: no side effects. Illegal -> TRAP with err_code_o=01. Otherwise -> EXECUTE.
//  EXECUTE: one cycle.
//   RTYPE: alu_op=10, alu_src=0 -> WB.
//   OPIMM: alu_op=11, alu_src=1 -> WB.
//   LOAD/STORE: alu_op=00, alu_src=1 -> MEM.
//   BRANCH: alu_op=01, alu_src=0, branch_o=1, retire_o=1 -> FETCH.
//  MEM: mem_req_o=1, iord_o=1, mem_we_o=(STORE). On mem_ready_i=1: STORE retires -> FETCH;
//   LOAD -> WB.
//  WB: reg_write_o=1, mem_to_reg_o=(LOAD), retire_o=1 -> FETCH.
//  Handshake: transfer occurs on cycle with mem_req_o & mem_ready_i. iord_o and mem_we_o
//   stay stable while mem_req_o=1. mem_req_o drops the cycle after transfer because the
//   state changes. mem_ready_i is ignored when mem_req_o=0.
//  Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle with
//   mem_req_o=1 & !mem_ready_i. When counter==MEM_TIMEOUT (MEM_TIMEOUT!=0) and ready is
//   still low -> TRAP, err_code_o=10. Ready in the same cycle as the limit wins: transfer
//   completes and no trap.
//  TRAP: all controls 0, state held, err_code_o sticky. Only rst_i exits.
//  retired_cnt_o increments registered on each retire_o; 2^CNT_W-1 wraps to 0.
//  Latency with zero-wait memory, in cycles: RTYPE/OPIMM 4, LOAD 5, STORE 4, BRANCH 3.
// TESTING
//  1 Reset release, ready tied 1, opcode 0110011 -> states 0,1,2,3,5,1...; retire every
//    4 cycles; alu_op 10 in EXECUTE.
//  2 LOAD 0000011 with ready low 3 cycles in MEM -> mem_req_o held 4 cycles, iord_o=1,
//    we=0; WB has mem_to_reg_o=1 and reg_write_o=1.
//  3 STORE 0100011, ready=1 -> mem_we_o=1 for one MEM cycle; retire in MEM; no
//    reg_write_o.
//  4 BRANCH 1100011 -> branch_o=1 and retire_o=1 in the single EXECUTE cycle; FETCH next.
//  5 Opcode 1111111 -> TRAP, err_code_o=01, held 20 cycles; rst_i pulse mid-cycle returns
//    IDLE asynchronously with count 0.
//  6 MEM_TIMEOUT=4, ready low in FETCH -> TRAP after 4 waits, err_code_o=10. Repeat with
//    ready arriving on the 4th wait -> no trap. CNT_W=4: 16 retires -> count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: steps one RV32I-subset instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// sharing one memory port via req/ready, with a retired counter and a sticky trap state.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             branch_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic [2:0]       state_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [1:0]       err_code_o
);
    localparam int                WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic              TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_OPIMM,
        CLS_RTYPE,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } cls_t;

    state_t            state, state_next;
    cls_t              cls, dec_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        err_code, err_next;
    logic [CNT_W-1:0]  retired_cnt;
    logic              timeout_hit;

    always_comb begin
        case (opcode_i)
            OP_OPIMM:  dec_cls = CLS_OPIMM;
            OP_RTYPE:  dec_cls = CLS_RTYPE;
            OP_BRANCH: dec_cls = CLS_BRANCH;
            OP_LOAD:   dec_cls = CLS_LOAD;
            OP_STORE:  dec_cls = CLS_STORE;
            default:   dec_cls = CLS_ILLEGAL;
        endcase
    end

    // Ready arriving in the limit cycle wins, since the FETCH/MEM branches test ready first.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        state_next   = state;
        err_next     = err_code;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = 2'b00;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        retire_o     = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    err_next   = 2'b10;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (dec_cls == CLS_ILLEGAL) begin
                    err_next   = 2'b01;
                    state_next = S_TRAP;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls)
                    CLS_RTYPE: begin
                        alu_op_o   = 2'b10;
                        state_next = S_WB;
                    end
                    CLS_OPIMM: begin
                        alu_op_o   = 2'b11;
                        alu_src_o  = 1'b1;
                        state_next = S_WB;
                    end
                    CLS_BRANCH: begin
                        alu_op_o   = 2'b01;
                        branch_o   = 1'b1;
                        retire_o   = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        alu_src_o  = 1'b1;
                        state_next = S_MEM;
                    end
                endcase
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = (cls == CLS_STORE);
                if (mem_ready_i) begin
                    if (cls == CLS_STORE) begin
                        retire_o   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    err_next   = 2'b10;
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (cls == CLS_LOAD);
                retire_o     = 1'b1;
                state_next   = S_FETCH;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cls         <= CLS_ILLEGAL;
            wait_cnt    <= '0;
            err_code    <= 2'b00;
            retired_cnt <= '0;
        end else begin
            state    <= state_next;
            err_code <= err_next;
            if (state == S_DECODE) begin
                cls <= dec_cls;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (TIMEOUT_EN && mem_req_o && !mem_ready_i && !timeout_hit) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire_o) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o       = state;
    assign err_code_o    = err_code;
    assign retired_cnt_o = retired_cnt;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized scoreboard bench for multicycle_ctrl_fsm (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_ctrl_fsm;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int K_XFER = 0;
    localparam int K_RET  = 1;
    localparam int K_TRAP = 2;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [6:0]    opcode_i = 7'd0;
    logic          mem_ready_i = 1'b0;
    logic          mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, branch_o, alu_src_o;
    logic [1:0]    alu_op_o;
    logic          reg_write_o, mem_to_reg_o, retire_o;
    logic [2:0]    state_o;
    logic [CW-1:0] retired_cnt_o;
    logic [1:0]    err_code_o;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
        .pc_write_o(pc_write_o), .branch_o(branch_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
        .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .state_o(state_o),
        .retire_o(retire_o), .retired_cnt_o(retired_cnt_o), .err_code_o(err_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         kind;
        logic       iord, we, irpc;
        int         waits;
        logic       rw, m2r, br, asrc;
        logic [1:0] aop;
        int         lat;
        logic [3:0] cnt;
        logic [1:0] err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [12:0] ctrl_vec();
        return {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, branch_o, alu_src_o,
                alu_op_o, reg_write_o, mem_to_reg_o, retire_o, 1'b0};
    endfunction

    // Reference model: what each instruction class must produce, in event order.
    task automatic model_instr(input logic [6:0] op, input int wf, input int wm);
        exp_t e;
        e = '{kind: K_XFER, iord: 0, we: 0, irpc: 1, waits: wf, rw: 0, m2r: 0, br: 0,
              asrc: 0, aop: 2'b00, lat: 0, cnt: 4'd0, err: 2'b00};
        q.push_back(e);
        if (op != OP_OPIMM && op != OP_RTYPE && op != OP_BRANCH && op != OP_LOAD && op != OP_STORE) begin
            e.kind = K_TRAP; e.err = 2'b01;
            q.push_back(e);
            return;
        end
        if (op == OP_LOAD || op == OP_STORE) begin
            e.iord = 1; e.we = (op == OP_STORE); e.irpc = 0; e.waits = wm;
            q.push_back(e);
        end
        e.kind = K_RET; e.iord = 0; e.we = 0; e.irpc = 0; e.waits = 0;
        case (op)
            OP_RTYPE:  begin e.aop = 2'b10; e.asrc = 0; e.rw = 1; e.lat = 4 + wf; end
            OP_OPIMM:  begin e.aop = 2'b11; e.asrc = 1; e.rw = 1; e.lat = 4 + wf; end
            OP_BRANCH: begin e.aop = 2'b01; e.asrc = 0; e.br = 1; e.lat = 3 + wf; end
            OP_LOAD:   begin e.aop = 2'b00; e.asrc = 1; e.rw = 1; e.m2r = 1; e.lat = 5 + wf + wm; end
            default:   begin e.aop = 2'b00; e.asrc = 1; e.lat = 4 + wf + wm; end
        endcase
        model_cnt = (model_cnt + 1) % (1 << CW);
        e.cnt = 4'(model_cnt);
        q.push_back(e);
    endtask

    // Monitor: pops an expectation whenever the DUT shows a transfer, retire or trap entry.
    exp_t       me;
    int         req_run = 0;
    int         start_cyc = 0;
    logic [2:0] prev_state = 3'd0;
    logic [1:0] ex_aop = 2'b00;
    logic       ex_asrc = 1'b0;
    logic       pend = 1'b0;
    logic [3:0] pend_val = 4'd0;

    task automatic pop_exp(input string what, output exp_t e);
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_%s: got event expected none (cycle %0d)", what, cyc);
            e = '{kind: -1, iord: 0, we: 0, irpc: 0, waits: 0, rw: 0, m2r: 0, br: 0,
                  asrc: 0, aop: 2'b00, lat: 0, cnt: 4'd0, err: 2'b00};
        end else begin
            e = q.pop_front();
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_i) begin
            req_run = 0; prev_state = 3'd0; pend = 1'b0;
        end else begin
            if (pend) begin
                check("retired_cnt", 32'(retired_cnt_o), 32'(pend_val));
                pend = 1'b0;
            end
            if (state_o == 3'd1 && prev_state != 3'd1) start_cyc = cyc;
            if (state_o == 3'd3) begin ex_aop = alu_op_o; ex_asrc = alu_src_o; end
            if (mem_req_o) begin
                if (mem_ready_i) begin
                    pop_exp("xfer", me);
                    check("xfer_kind", 32'(me.kind), 32'(K_XFER));
                    check("xfer_iord", 32'(iord_o), 32'(me.iord));
                    check("xfer_we", 32'(mem_we_o), 32'(me.we));
                    check("xfer_irpc", {30'd0, ir_write_o, pc_write_o}, {30'd0, me.irpc, me.irpc});
                    check("xfer_waits", 32'(req_run), 32'(me.waits));
                    req_run = 0;
                end else begin
                    req_run++;
                end
            end
            if (retire_o) begin
                pop_exp("retire", me);
                check("ret_kind", 32'(me.kind), 32'(K_RET));
                check("ret_regwrite", 32'(reg_write_o), 32'(me.rw));
                check("ret_mem2reg", 32'(mem_to_reg_o), 32'(me.m2r));
                check("ret_branch", 32'(branch_o), 32'(me.br));
                check("ret_aluop", 32'(ex_aop), 32'(me.aop));
                check("ret_alusrc", 32'(ex_asrc), 32'(me.asrc));
                check("ret_latency", 32'(cyc - start_cyc + 1), 32'(me.lat));
                pend = 1'b1; pend_val = me.cnt;
            end
            if (state_o == 3'd6 && prev_state != 3'd6) begin
                pop_exp("trap", me);
                check("trap_kind", 32'(me.kind), 32'(K_TRAP));
                check("trap_err", 32'(err_code_o), 32'(me.err));
            end
            prev_state = state_o;
        end
    end

    // Stimulus side
    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int g = 0;
        while (state_o != s && g < limit) begin @(posedge clk_i); #1; g++; end
        if (state_o != s) check(name, 32'(state_o), 32'(s));
    endtask

    task automatic serve(input int w);
        int g = 0;
        while (!mem_req_o && g < 20) begin @(posedge clk_i); #1; g++; end
        if (!mem_req_o) begin
            check("req_seen", 32'(mem_req_o), 32'd1);
            return;
        end
        repeat (w) begin mem_ready_i = 1'b0; @(posedge clk_i); #1; end
        mem_ready_i = 1'b1; @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
    endtask

    task automatic run(input logic [6:0] op, input int wf, input int wm);
        model_instr(op, wf, wm);
        wait_state(3'd1, 20, "fetch_reached");
        opcode_i = op;
        serve(wf);
        if (op == OP_LOAD || op == OP_STORE) serve(wm);
    endtask

    task automatic async_reset();
        @(posedge clk_i); #3;
        rst_i = 1'b1; #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_cnt", 32'(retired_cnt_o), 32'd0);
        check("async_rst_err", 32'(err_code_o), 32'd0);
        q.delete();
        model_cnt = 0;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic trap_hold(input logic [1:0] err);
        wait_state(3'd6, 40, "trap_reached");
        repeat (20) @(posedge clk_i);
        #1;
        check("trap_hold_state", 32'(state_o), 32'd6);
        check("trap_hold_err", 32'(err_code_o), 32'(err));
        check("trap_hold_ctrl", 32'(ctrl_vec()), 32'd0);
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO)) : 0;
    endfunction

    logic [6:0] legal [5] = '{OP_OPIMM, OP_RTYPE, OP_BRANCH, OP_LOAD, OP_STORE};

    initial begin
        logic [6:0] op;
        int         g;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_cnt", 32'(retired_cnt_o), 32'd0);
        check("reset_err", 32'(err_code_o), 32'd0);
        check("reset_ctrl", 32'(ctrl_vec()), 32'd0);
        rst_i = 1'b0;

        run(OP_RTYPE, 0, 0);
        run(OP_RTYPE, 0, 0);
        run(OP_LOAD, 0, 3);
        run(OP_STORE, 0, 0);
        run(OP_BRANCH, 0, 0);
        run(OP_OPIMM, TO, TO);
        run(OP_STORE, 1, TO);
        for (int i = 0; i < 60; i++) begin
            op = legal[$urandom_range(0, 4)];
            run(op, rand_wait(), rand_wait());
        end

        // No responder on the next fetch: memory timeout trap.
        q.push_back('{kind: K_TRAP, iord: 0, we: 0, irpc: 0, waits: 0, rw: 0, m2r: 0, br: 0,
                      asrc: 0, aop: 2'b00, lat: 0, cnt: 4'd0, err: 2'b10});
        trap_hold(2'b10);
        async_reset();

        run(7'b1111111, rand_wait(), 0);
        trap_hold(2'b01);
        async_reset();

        // Abort a load while it waits in MEM.
        run(OP_RTYPE, 0, 0);
        model_instr(OP_LOAD, 0, 0);
        wait_state(3'd1, 20, "fetch_reached");
        opcode_i = OP_LOAD;
        serve(0);
        wait_state(3'd4, 10, "mem_reached");
        @(posedge clk_i); #1;
        async_reset();
        check("abort_regwrite", 32'(reg_write_o), 32'd0);

        run(OP_OPIMM, 0, 0);
        run(OP_LOAD, 2, 1);
        g = 0;
        while (q.size() != 0 && g < 20) begin @(posedge clk_i); g++; end
        @(negedge clk_i); @(negedge clk_i);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("final_cnt", 32'(retired_cnt_o), 32'(model_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
